// File: rtl/pin_conditioner_if.sv
// Bundles the raw MCU pins and the conditioned signals handed to the core top.
// master drives the pins (pad side); slave is the conditioner itself.
interface pin_conditioner_if;
  logic       t0_pin;
  logic       t1_pin;
  logic       int0_pin;
  logic       int1_pin;
  logic       rxd_pin;
  logic [1:0] it_mode;
  logic       cnt_0;
  logic       cnt_1;
  logic       inti0;
  logic       inti1;
  logic       rxd;
  logic       rxd_fall;

  modport master (
    output t0_pin, t1_pin, int0_pin, int1_pin, rxd_pin, it_mode,
    input  cnt_0, cnt_1, inti0, inti1, rxd, rxd_fall
  );

  modport slave (
    input  t0_pin, t1_pin, int0_pin, int1_pin, rxd_pin, it_mode,
    output cnt_0, cnt_1, inti0, inti1, rxd, rxd_fall
  );
endinterface

// File: rtl/pin_conditioner.sv
// Synchronises the async MCU pins; T0/T1/INT0/INT1 are also debounced into
// count pulses and interrupt requests, while RXD is only synchronised.
module pin_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pin_conditioner_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // channel index: 0=T0, 1=T1, 2=INT0, 3=INT1, 4=RXD (sync only)
  logic [4:0]             w_pin;
  logic [4:0]             w_sync;
  logic [SYNC_STAGES-1:0] r_sync [5];
  logic [3:0]             r_filt;
  logic [CW-1:0]          r_db_cnt [4];
  logic [3:0]             w_filt_next;
  logic [3:0]             w_fall;
  logic                   r_cnt0_pulse;
  logic                   r_cnt1_pulse;
  logic                   r_inti0;
  logic                   r_inti1;
  logic                   r_rxd_fall;

  assign w_pin = {bus.rxd_pin, bus.int1_pin, bus.int0_pin, bus.t1_pin, bus.t0_pin};

  always_comb begin
    w_sync      = '0;
    w_filt_next = r_filt;
    for (int i = 0; i < 5; i++) begin
      w_sync[i] = r_sync[i][SYNC_STAGES-1];
    end
    for (int i = 0; i < 4; i++) begin
      if ((w_sync[i] != r_filt[i]) && (r_db_cnt[i] == C_MAX)) begin
        w_filt_next[i] = w_sync[i];
      end
    end
  end

  assign w_fall = r_filt & ~w_filt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_sync[i] <= '1;
      end
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_filt       <= '1;
      r_cnt0_pulse <= 1'b0;
      r_cnt1_pulse <= 1'b0;
      r_inti0      <= 1'b0;
      r_inti1      <= 1'b0;
      r_rxd_fall   <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_pin[i]};
      end
      // counter restarts both when the level is stable and when it is accepted
      for (int i = 0; i < 4; i++) begin
        if ((w_sync[i] == r_filt[i]) || (r_db_cnt[i] == C_MAX)) begin
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
      r_filt       <= w_filt_next;
      r_cnt0_pulse <= w_fall[0];
      r_cnt1_pulse <= w_fall[1];
      r_inti0      <= bus.it_mode[0] ? w_fall[2] : ~w_filt_next[2];
      r_inti1      <= bus.it_mode[1] ? w_fall[3] : ~w_filt_next[3];
      // looks one stage ahead so the pulse lines up with the first low rxd
      r_rxd_fall   <= w_sync[4] & ~r_sync[4][SYNC_STAGES-2];
    end
  end

  assign bus.cnt_0    = r_cnt0_pulse;
  assign bus.cnt_1    = r_cnt1_pulse;
  assign bus.inti0    = r_inti0;
  assign bus.inti1    = r_inti1;
  assign bus.rxd      = w_sync[4];
  assign bus.rxd_fall = r_rxd_fall;

endmodule

// File: tb/tb_pin_conditioner.sv
// Directed bench for pin_conditioner: expected output vectors are queued when
// pins are driven and popped/compared one per clock, 1 time unit after the edge.
module tb_pin_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LAT = SS + DB;
  localparam logic [5:0] IDLE = 6'b100000; // {rxd, rxd_fall, inti1, inti0, cnt_1, cnt_0}

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  pin_conditioner_if bus ();

  pin_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] observed();
    return {bus.rxd, bus.rxd_fall, bus.inti1, bus.inti0, bus.cnt_1, bus.cnt_0};
  endfunction

  task automatic push(input string tag, input logic [5:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [5:0] obs;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", observed());
    end else begin
      e = exp_q.pop_front();
      obs = observed();
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // mask bits: 0=T0 1=T1 2=INT0 3=INT1 4=RXD
  task automatic set_pins(input logic [4:0] mask, input logic lvl);
    if (mask[0]) bus.t0_pin   = lvl;
    if (mask[1]) bus.t1_pin   = lvl;
    if (mask[2]) bus.int0_pin = lvl;
    if (mask[3]) bus.int1_pin = lvl;
    if (mask[4]) bus.rxd_pin  = lvl;
  endtask

  // Pins in mask held low for edges 1..len, then high; n edges observed.
  task automatic low_pulse(input string tag, input logic [4:0] mask, input int len, input int n);
    logic f_low, fall, rlow;
    logic [5:0] v;
    for (int k = 1; k <= n; k++) begin
      f_low = (len >= DB) && (k >= LAT) && (k < len + LAT);
      fall  = (len >= DB) && (k == LAT);
      rlow  = mask[4] && (k >= SS) && (k < len + SS);
      v[0] = mask[0] & fall;
      v[1] = mask[1] & fall;
      v[2] = mask[2] & (bus.it_mode[0] ? fall : f_low);
      v[3] = mask[3] & (bus.it_mode[1] ? fall : f_low);
      v[4] = mask[4] & (k == SS);
      v[5] = ~rlow;
      push($sformatf("%s_k%0d", tag, k), v);
    end
    set_pins(mask, 1'b0);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == len) set_pins(mask, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.t0_pin = 1'b1; bus.t1_pin = 1'b1; bus.int0_pin = 1'b1;
    bus.int1_pin = 1'b1; bus.rxd_pin = 1'b1; bus.it_mode = 2'b00;
    rst_n = 1'b0;
    #12;
    push("reset_state", IDLE);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) push($sformatf("idle_k%0d", k), IDLE);
    for (int k = 0; k < 3; k++) tick();

    low_pulse("t0_low10", 5'b00001, 10, 20);
    low_pulse("t1_glitch3", 5'b00010, 3, 12);
    low_pulse("t1_low4", 5'b00010, 4, 14);
    bus.it_mode = 2'b00;
    low_pulse("int0_level", 5'b00100, 20, 30);
    bus.it_mode = 2'b01;
    low_pulse("int0_edge", 5'b00100, 20, 30);
    low_pulse("rxd_fall", 5'b10000, 8, 12);
    bus.it_mode = 2'b11;
    low_pulse("all_pins", 5'b11111, 6, 16);
    bus.it_mode = 2'b10;
    low_pulse("int1_edge_int0_lvl", 5'b01100, 7, 16);

    // reset while T0 debounce counter sits at 2
    bus.it_mode = 2'b11;
    for (int k = 1; k <= 4; k++) push($sformatf("pre_rst_k%0d", k), IDLE);
    set_pins(5'b00001, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    #1;
    push("in_reset", IDLE);
    check_now();
    for (int k = 1; k <= 3; k++) push($sformatf("in_reset_k%0d", k), IDLE);
    for (int k = 1; k <= 3; k++) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++)
      push($sformatf("post_rst_k%0d", k), (k == LAT) ? 6'b100001 : IDLE);
    for (int k = 1; k <= 12; k++) tick();
    set_pins(5'b00001, 1'b1);
    for (int k = 1; k <= 8; k++) push($sformatf("post_rst_rise_k%0d", k), IDLE);
    for (int k = 1; k <= 8; k++) tick();

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
